// File: rtl/fmac_dot_seq.sv
// Dot-product sequencer around a float8 (1s/4e bias 7/3m) multiply-accumulate.
// The MAC flushes exponent-0 operands to zero, truncates toward zero,
// flushes underflow to zero and saturates overflow to the largest finite value.

module fmac8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] c,
   output logic [7:0] d
);
   // Fixed-point weights: LSB = 2^-18, which covers every product and addend exactly.
   logic               a_zero, b_zero, c_zero, p_sign, r_sign;
   logic [7:0]         prod;
   logic [4:0]         p_shift;
   logic [4:0]         c_shift;
   logic [38:0]        p_mag, c_mag;
   logic signed [40:0] p_val, c_val, sum;
   logic [40:0]        mag, mag_sh;
   logic [5:0]         lead;
   logic [5:0]         e_raw;

   // Exact aligned sum, then renormalise to float8 with truncation.
   always_comb begin
      a_zero  = (a[6:3] == 4'd0);
      b_zero  = (b[6:3] == 4'd0);
      c_zero  = (c[6:3] == 4'd0);
      p_sign  = a[7] ^ b[7];
      prod    = {4'd0, 1'b1, a[2:0]} * {4'd0, 1'b1, b[2:0]};
      p_shift = {1'b0, a[6:3]} + {1'b0, b[6:3]} - 5'd2;
      c_shift = {1'b0, c[6:3]} + 5'd8;
      p_mag   = (a_zero || b_zero) ? 39'd0 : ({31'd0, prod} << p_shift);
      c_mag   = c_zero ? 39'd0 : ({35'd0, 1'b1, c[2:0]} << c_shift);
      p_val   = p_sign ? -$signed({2'b00, p_mag}) : $signed({2'b00, p_mag});
      c_val   = c[7] ? -$signed({2'b00, c_mag}) : $signed({2'b00, c_mag});
      sum     = p_val + c_val;
      r_sign  = sum[40];
      mag     = r_sign ? 41'(-sum) : 41'(sum);
      lead    = 6'd0;
      for (int i = 0; i < 41; i++) begin
         if (mag[i]) lead = 6'(i);
      end
      e_raw   = lead - 6'd11;
      mag_sh  = mag >> (lead - 6'd3);
      if (mag == 41'd0 || lead < 6'd12) begin
         d = 8'h00;
      end else if (lead > 6'd26) begin
         d = {r_sign, 7'h7F};
      end else begin
         d = {r_sign, e_raw[3:0], mag_sh[2:0]};
      end
   end
endmodule

module fmac_dot_seq #(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [7:0]       acc_init,
   input  logic             abort,
   input  logic [7:0]       a_data,
   input  logic [7:0]       b_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       res_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             busy,
   output logic [15:0]      jobs_done
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [7:0]       acc_q, acc_d;
   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic [15:0]      jobs_done_q, jobs_done_d;
   logic             in_ready_q, res_valid_q, busy_q;
   logic [7:0]       mac_d;
   logic             beat;

   fmac8 u_mac (
      .a (a_data),
      .b (b_data),
      .c (acc_q),
      .d (mac_d)
   );

   assign beat = in_valid && in_ready_q;

   // Next-state logic: abort overrides everything, start only counts in IDLE.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      remaining_d = remaining_q;
      jobs_done_d = jobs_done_q;
      if (abort) begin
         state_d     = IDLE;
         acc_d       = 8'h00;
         remaining_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  acc_d = acc_init;
                  if (len == '0) begin
                     state_d = DONE;
                  end else begin
                     remaining_d = len;
                     state_d     = RUN;
                  end
               end
            end
            RUN: begin
               if (beat) begin
                  acc_d       = mac_d;
                  remaining_d = remaining_q - 1'b1;
                  if (remaining_q == LEN_W'(1)) state_d = DONE;
               end
            end
            DONE: begin
               if (res_ready) begin
                  state_d     = IDLE;
                  jobs_done_d = jobs_done_q + 16'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and registered handshake outputs, derived from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= 8'h00;
         remaining_q <= '0;
         jobs_done_q <= 16'd0;
         in_ready_q  <= 1'b0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         remaining_q <= remaining_d;
         jobs_done_q <= jobs_done_d;
         in_ready_q  <= (state_d == RUN);
         res_valid_q <= (state_d == DONE);
         busy_q      <= (state_d != IDLE);
      end
   end

   assign in_ready  = in_ready_q;
   assign res_valid = res_valid_q;
   assign res_data  = acc_q;
   assign busy      = busy_q;
   assign jobs_done = jobs_done_q;
endmodule
